data_mem_responder: RTL and testbench

- Memory-side responder for the multicycle core's data port.
- Accepts the core's MemRead/MemWrite, dAddress and dWriteData, and returns dReadData one clock later, in time for the core's write-back state.
- Backs a word-addressed RAM window and a small memory-mapped I/O window: LED register, free-running cycle counter, status word.
- Flags illegal accesses in a sticky error bit.

---
 rtl/data_mem_responder.sv | 92 +++++++++
 tb/tb_data_mem_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-port responder for the multicycle core: RAM window plus LED/CYCLE/STATUS MMIO.
// Read data is registered, so it lands one clock after the request.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF0000,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic [31:0] led,
    output logic        err
);
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 2;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;
    logic [31:0] r_led;
    logic [31:0] r_cnt;
    logic        r_err;
    logic        r_wr_q;

    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_ram_hit;
    logic             w_led_hit;
    logic             w_cyc_hit;
    logic             w_st_hit;
    logic             w_misal;
    logic             w_illegal;
    logic             w_wr_edge;
    logic             w_wr_ram;
    logic             w_wr_led;
    logic [31:0]      w_rsel;

    // Offset test avoids overflow of BASE_ADDR + RAM_BYTES near the top of the map.
    assign w_off     = dAddress - BASE_ADDR;
    assign w_idx     = w_off[IDX_W+1:2];
    assign w_ram_hit = (dAddress >= BASE_ADDR) && (w_off < RAM_BYTES);
    assign w_led_hit = (dAddress == MMIO_ADDR);
    assign w_cyc_hit = (dAddress == MMIO_ADDR + 32'd4);
    assign w_st_hit  = (dAddress == MMIO_ADDR + 32'd8);
    assign w_misal   = |dAddress[1:0];

    assign w_illegal = (MemRead | MemWrite) &
                       (~(w_ram_hit | w_led_hit | w_cyc_hit | w_st_hit) | w_misal |
                        (MemWrite & (w_cyc_hit | w_st_hit)) | (MemRead & MemWrite));

    // A held MemWrite commits once, on its rising edge only.
    assign w_wr_edge = MemWrite & ~r_wr_q & ~w_illegal & ~rst;
    assign w_wr_ram  = w_wr_edge & w_ram_hit;
    assign w_wr_led  = w_wr_edge & w_led_hit;

    always_comb begin
        w_rsel = 32'd0;
        if (w_ram_hit)      w_rsel = r_mem[w_idx];
        else if (w_led_hit) w_rsel = r_led;
        else if (w_cyc_hit) w_rsel = r_cnt;
        else if (w_st_hit)  w_rsel = {31'd0, r_err};
    end

    // RAM has no reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (w_wr_ram) r_mem[w_idx] <= dWriteData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_led   <= 32'd0;
            r_cnt   <= 32'd0;
            r_err   <= 1'b0;
            r_wr_q  <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + 32'd1;
            r_wr_q <= MemWrite;
            if (w_wr_led) r_led <= dWriteData;
            if (w_illegal) r_err <= 1'b1;
            if (MemRead) r_rdata <= w_illegal ? ERR_DATA : w_rsel;
        end
    end

    assign dReadData = r_rdata;
    assign led       = r_led;
    assign err       = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder; expected values are hand-computed.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;
    logic [31:0] led;
    logic        err;

    int n_tot = 0;
    int n_bad = 0;

    data_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .dAddress   (dAddress),
        .dWriteData (dWriteData),
        .dReadData  (dReadData),
        .led        (led),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of request, then step just past the edge.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        MemRead    = rd;
        MemWrite   = wr;
        dAddress   = a;
        dWriteData = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; dAddress = 32'h0; dWriteData = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_rdata", dReadData, 32'h0);
        chk("rst_led", led, 32'h0);
        chk("rst_err", {31'd0, err}, 32'h0);
        rst = 1'b0;

        // Cycle counter: 10th post-reset cycle sees 9, next sees 10.
        repeat (9) idle();
        req(1'b1, 1'b0, 32'hFFFF0004, 32'h0);
        chk("cyc9", dReadData, 32'd9);
        req(1'b1, 1'b0, 32'hFFFF0004, 32'h0);
        chk("cyc10", dReadData, 32'd10);

        // Store then load.
        req(1'b0, 1'b1, 32'h10010008, 32'h12345678);
        req(1'b1, 1'b0, 32'h10010008, 32'h0);
        chk("ld", dReadData, 32'h12345678);
        chk("ld_err", {31'd0, err}, 32'h0);
        req(1'b0, 1'b0, 32'hFFFF0004, 32'h0);
        chk("rd_hold", dReadData, 32'h12345678);

        // Held write commits only the first data word.
        req(1'b0, 1'b1, 32'h10010000, 32'hA);
        req(1'b0, 1'b1, 32'h10010000, 32'hB);
        req(1'b0, 1'b1, 32'h10010000, 32'hC);
        req(1'b1, 1'b0, 32'h10010000, 32'h0);
        chk("held_wr", dReadData, 32'hA);

        // LED register.
        req(1'b0, 1'b1, 32'hFFFF0000, 32'h000000FF);
        chk("led_wr", led, 32'h000000FF);
        req(1'b1, 1'b0, 32'hFFFF0000, 32'h0);
        chk("led_rd", dReadData, 32'h000000FF);
        req(1'b1, 1'b0, 32'hFFFF0008, 32'h0);
        chk("st0", dReadData, 32'h0);

        // Misaligned read.
        req(1'b1, 1'b0, 32'h10010002, 32'h0);
        chk("misal_rd", dReadData, 32'hDEADBEEF);
        chk("misal_err", {31'd0, err}, 32'h1);
        req(1'b1, 1'b0, 32'hFFFF0008, 32'h0);
        chk("st1", dReadData, 32'h1);
        idle();
        chk("err_sticky", {31'd0, err}, 32'h1);

        // Reset mid-sequence with led=FF, err=1.
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("rst2_led", led, 32'h0);
        chk("rst2_err", {31'd0, err}, 32'h0);
        chk("rst2_rdata", dReadData, 32'h0);
        req(1'b1, 1'b0, 32'hFFFF0004, 32'h0);
        chk("cyc_restart", dReadData, 32'd0);
        req(1'b1, 1'b0, 32'h10010008, 32'h0);
        chk("ram_kept", dReadData, 32'h12345678);
        req(1'b0, 1'b0, 32'h00000003, 32'h0);
        chk("idle_no_err", {31'd0, err}, 32'h0);

        // Unmapped write.
        req(1'b0, 1'b1, 32'h00000000, 32'h55);
        chk("unmap_wr_err", {31'd0, err}, 32'h1);

        // Write to CYCLE must not disturb the counter.
        rst = 1'b1;
        idle();
        rst = 1'b0;
        req(1'b0, 1'b1, 32'hFFFF0004, 32'h1234);
        chk("cyc_wr_err", {31'd0, err}, 32'h1);
        req(1'b1, 1'b0, 32'hFFFF0004, 32'h0);
        chk("cyc_wr_nochg", dReadData, 32'd1);

        // Simultaneous read and write at a valid RAM address.
        idle();
        req(1'b1, 1'b1, 32'h10010008, 32'h0);
        chk("rdwr_data", dReadData, 32'hDEADBEEF);
        chk("rdwr_err", {31'd0, err}, 32'h1);
        idle();
        req(1'b1, 1'b0, 32'h10010008, 32'h0);
        chk("rdwr_ram", dReadData, 32'h12345678);

        // Rising MemWrite under reset is lost; the post-reset cycle commits.
        rst = 1'b1;
        req(1'b0, 1'b1, 32'h10010004, 32'h55);
        rst = 1'b0;
        req(1'b0, 1'b1, 32'h10010004, 32'h55);
        req(1'b0, 1'b1, 32'h10010004, 32'h66);
        req(1'b1, 1'b0, 32'h10010004, 32'h0);
        chk("rst_wr_edge", dReadData, 32'h55);
        chk("rst_wr_err", {31'd0, err}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
